// File: rtl/pmod_pkg.sv
// rtl/pmod_pkg.sv - shared types and width defaults for the Pmod bus arbiter
package pmod_pkg;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int LW = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT_R = 2'd2,
      WAIT_B = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic          write;
      logic [LW-1:0] len;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } pmod_cmd_t;

endpackage

// File: rtl/pmod_bus_arb_if.sv
// rtl/pmod_bus_arb_if.sv - downstream memory access port shared by both requesters
interface pmod_bus_arb_if #(
   parameter int AW = pmod_pkg::AW,
   parameter int DW = pmod_pkg::DW,
   parameter int LW = pmod_pkg::LW
) ();

   logic          m_valid;
   logic          m_write;
   logic [LW-1:0] m_len;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_ready;
   logic          m_rvalid;
   logic [DW-1:0] m_rdata;
   logic          m_rlast;
   logic          m_bdone;

   modport master (
      output m_valid, m_write, m_len, m_addr, m_wdata,
      input  m_ready, m_rvalid, m_rdata, m_rlast, m_bdone
   );

   modport slave (
      input  m_valid, m_write, m_len, m_addr, m_wdata,
      output m_ready, m_rvalid, m_rdata, m_rlast, m_bdone
   );

endinterface

// File: rtl/pmod_req_slot.sv
// rtl/pmod_req_slot.sv - per-requester request latch, busy/ovf flags and read return register
module pmod_req_slot #(
   parameter int AW = pmod_pkg::AW,
   parameter int DW = pmod_pkg::DW,
   parameter int LW = pmod_pkg::LW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wreq,
   input  logic          rreq,
   input  logic [LW-1:0] len,
   input  logic [AW-1:0] address,
   input  logic [DW-1:0] wdata,
   input  logic          rbeat,
   input  logic          rdone,
   input  logic          wdone,
   input  logic [DW-1:0] beat_data,
   output logic          busy,
   output logic          rlast,
   output logic          ovf,
   output logic [DW-1:0] rdata,
   output logic          cmd_write,
   output logic [LW-1:0] cmd_len,
   output logic [AW-1:0] cmd_addr,
   output logic [DW-1:0] cmd_wdata
);

   logic req;

   assign req = wreq | rreq;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy      <= 1'b0;
         rlast     <= 1'b0;
         ovf       <= 1'b0;
         rdata     <= '0;
         cmd_write <= 1'b0;
         cmd_len   <= '0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else begin
         rlast <= rdone;
         if (rbeat) begin
            rdata <= beat_data;
         end
         if (rdone | wdone) begin
            busy <= 1'b0;
         end
         // Completion only happens while busy, so a request seen then is always a drop.
         if (req && busy) begin
            ovf <= 1'b1;
         end else if (req) begin
            busy      <= 1'b1;
            cmd_write <= wreq;
            cmd_len   <= len;
            cmd_addr  <= address;
            cmd_wdata <= wdata;
            if (wreq && rreq) begin
               ovf <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pmod_bus_arb.sv
// rtl/pmod_bus_arb.sv - round-robin arbiter sharing one memory access port between two requesters
module pmod_bus_arb #(
   parameter int AW = pmod_pkg::AW,
   parameter int DW = pmod_pkg::DW,
   parameter int LW = pmod_pkg::LW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          wreq,
   input  logic [1:0]          rreq,
   input  logic [1:0][LW-1:0]  len,
   input  logic [1:0][AW-1:0]  address,
   input  logic [1:0][DW-1:0]  wdata,
   output logic [1:0]          busy,
   output logic [1:0][DW-1:0]  rdata,
   output logic [1:0]          rlast,
   output logic [1:0]          ovf,
   pmod_bus_arb_if.master      mem
);

   import pmod_pkg::*;

   arb_state_t state;
   arb_state_t state_nxt;
   logic       last_grant;
   logic       grant_en;
   logic       grant_sel;

   logic [1:0]          cmd_write;
   logic [1:0][LW-1:0]  cmd_len;
   logic [1:0][AW-1:0]  cmd_addr;
   logic [1:0][DW-1:0]  cmd_wdata;
   logic [1:0]          rbeat;
   logic [1:0]          rdone;
   logic [1:0]          wdone;

   for (genvar i = 0; i < 2; i++) begin : g_slot
      pmod_req_slot #(.AW(AW), .DW(DW), .LW(LW)) u_slot (
         .clk       (clk),
         .reset     (reset),
         .wreq      (wreq[i]),
         .rreq      (rreq[i]),
         .len       (len[i]),
         .address   (address[i]),
         .wdata     (wdata[i]),
         .rbeat     (rbeat[i]),
         .rdone     (rdone[i]),
         .wdone     (wdone[i]),
         .beat_data (mem.m_rdata),
         .busy      (busy[i]),
         .rlast     (rlast[i]),
         .ovf       (ovf[i]),
         .rdata     (rdata[i]),
         .cmd_write (cmd_write[i]),
         .cmd_len   (cmd_len[i]),
         .cmd_addr  (cmd_addr[i]),
         .cmd_wdata (cmd_wdata[i])
      );
   end

   // last_grant doubles as the current owner from grant until completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (grant_en) begin
            last_grant <= grant_sel;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      grant_sel = last_grant;
      case (state)
         IDLE: begin
            if (|busy) begin
               grant_en  = 1'b1;
               grant_sel = (&busy) ? ~last_grant : busy[1];
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (mem.m_ready) begin
               state_nxt = cmd_write[last_grant] ? WAIT_B : WAIT_R;
            end
         end
         WAIT_R: begin
            if (mem.m_rvalid && mem.m_rlast) begin
               state_nxt = IDLE;
            end
         end
         WAIT_B: begin
            if (mem.m_bdone) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem.m_valid = (state == ISSUE);
      mem.m_write = cmd_write[last_grant];
      mem.m_len   = cmd_len[last_grant];
      mem.m_addr  = cmd_addr[last_grant];
      mem.m_wdata = cmd_wdata[last_grant];
      rbeat = '0;
      rdone = '0;
      wdone = '0;
      rbeat[last_grant] = (state == WAIT_R) && mem.m_rvalid;
      rdone[last_grant] = (state == WAIT_R) && mem.m_rvalid && mem.m_rlast;
      wdone[last_grant] = (state == WAIT_B) && mem.m_bdone;
   end

endmodule

// File: tb/tb_pmod_bus_arb.sv
// tb/tb_pmod_bus_arb.sv - self-checking bench for pmod_bus_arb
`timescale 1ns/1ps
module tb_pmod_bus_arb;
   import pmod_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0]          wreq, rreq, busy, rlast, ovf;
   logic [1:0][LW-1:0]  len;
   logic [1:0][AW-1:0]  address;
   logic [1:0][DW-1:0]  wdata, rdata;

   pmod_bus_arb_if bus ();

   pmod_bus_arb dut (
      .clk(clk), .reset(reset), .wreq(wreq), .rreq(rreq), .len(len),
      .address(address), .wdata(wdata), .busy(busy), .rdata(rdata),
      .rlast(rlast), .ovf(ovf), .mem(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pending slot contents, sticky drops, last winner, last read beat.
   pmod_cmd_t     mdl_slot [2];
   bit            mdl_pend [2];
   bit            mdl_ovf  [2];
   bit            mdl_last;
   logic [DW-1:0] mdl_rd   [2];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wreq = '0; rreq = '0;
      bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
      bus.m_bdone = 1'b0; bus.m_rdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mdl_pend[i] = 1'b0; mdl_ovf[i] = 1'b0; mdl_rd[i] = '0; mdl_slot[i] = '0;
      end
      mdl_last = 1'b1;
   endtask

   function automatic pmod_cmd_t rand_cmd(bit w);
      pmod_cmd_t c;
      logic [31:0] u;
      u = $urandom;
      c.write = w;
      c.len   = u[LW-1:0];
      c.addr  = $urandom;
      c.wdata = {$urandom, $urandom};
      return c;
   endfunction

   task automatic drive_req(int r, bit w, bit rd, pmod_cmd_t c);
      wreq[r] = w; rreq[r] = rd;
      len[r] = c.len; address[r] = c.addr; wdata[r] = c.wdata;
      if (w || rd) begin
         if (mdl_pend[r]) begin
            mdl_ovf[r] = 1'b1;
         end else begin
            mdl_pend[r] = 1'b1;
            mdl_slot[r] = c;
            mdl_slot[r].write = w;
            if (w && rd) mdl_ovf[r] = 1'b1;
         end
      end
   endtask

   function automatic int model_pick();
      int r;
      if (mdl_pend[0] && mdl_pend[1]) r = mdl_last ? 0 : 1;
      else r = mdl_pend[1] ? 1 : 0;
      mdl_last = r[0];
      return r;
   endfunction

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.m_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      len = '0; address = '0; wdata = '0;
      bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_bdone = 1'b1;
      bus.m_rdata = 64'h1111_2222_3333_4444;
      cyc(); cyc();
      reset = 1'b0;
      n_cmp++;
      if ({busy, rlast, ovf} !== 6'b0) begin
         n_bad++; $display("FAIL reset_flags: got busy=%b rlast=%b ovf=%b want all 0", busy, rlast, ovf);
      end
      n_cmp++;
      if (rdata !== '0) begin
         n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata);
      end
      n_cmp++;
      if ({bus.m_valid, bus.m_write} !== 2'b00 || bus.m_len !== '0 || bus.m_addr !== '0 || bus.m_wdata !== '0) begin
         n_bad++; $display("FAIL reset_cmd: got v=%b w=%b l=%h a=%h d=%h want all 0",
                           bus.m_valid, bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata);
      end
      cyc();
      idle_inputs();
      cyc();
      n_cmp++;
      if ({busy, rlast, bus.m_valid} !== 5'b0 || rdata !== '0) begin
         n_bad++; $display("FAIL reset_stray: got busy=%b rlast=%b v=%b rdata=%h want idle", busy, rlast, bus.m_valid, rdata);
      end
   endtask

   task automatic test_single_read();
      pmod_cmd_t c;
      do_reset();
      c = '0;
      c.len = 10'd1;
      c.addr = 32'h1000_0008;
      drive_req(0, 1'b0, 1'b1, c);
      cyc();
      wreq = '0; rreq = '0;
      n_cmp++;
      if (busy[0] !== 1'b1 || bus.m_valid !== 1'b0) begin
         n_bad++; $display("FAIL sr_busy_n1: got busy0=%b v=%b want 1 0", busy[0], bus.m_valid);
      end
      cyc();
      n_cmp++;
      if (bus.m_valid !== 1'b1 || bus.m_write !== 1'b0 || bus.m_addr !== 32'h1000_0008 || bus.m_len !== 10'd1) begin
         n_bad++; $display("FAIL sr_issue_n2: got v=%b w=%b a=%h l=%0d want 1 0 10000008 1",
                           bus.m_valid, bus.m_write, bus.m_addr, bus.m_len);
      end
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = 64'hDEAD_BEEF_0123_4567;
      n_cmp++;
      if (busy[0] !== 1'b1 || rlast[0] !== 1'b0 || bus.m_valid !== 1'b0) begin
         n_bad++; $display("FAIL sr_wait: got busy0=%b rlast0=%b v=%b want 1 0 0", busy[0], rlast[0], bus.m_valid);
      end
      cyc();
      idle_inputs();
      n_cmp++;
      if (rdata[0] !== 64'hDEAD_BEEF_0123_4567 || rlast[0] !== 1'b1 || busy[0] !== 1'b0) begin
         n_bad++; $display("FAIL sr_done: got rdata0=%h rlast0=%b busy0=%b want deadbeef01234567 1 0", rdata[0], rlast[0], busy[0]);
      end
      cyc();
      n_cmp++;
      if (rlast[0] !== 1'b0 || rdata[0] !== 64'hDEAD_BEEF_0123_4567) begin
         n_bad++; $display("FAIL sr_hold: got rlast0=%b rdata0=%h want 0 deadbeef01234567", rlast[0], rdata[0]);
      end
   endtask

   task automatic test_ready_stall();
      pmod_cmd_t c;
      bit ok;
      c = rand_cmd(1'b1);
      drive_req(1, 1'b1, 1'b0, c);
      cyc();
      wreq = '0; rreq = '0;
      wait_valid(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL st_timeout: got no m_valid want m_valid within 20 cycles");
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (bus.m_valid !== 1'b1 || {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata} !== c) begin
            n_bad++; $display("FAIL st_hold%0d: got v=%b cmd=%h want 1 %h", i, bus.m_valid,
                              {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata}, c);
         end
         cyc();
      end
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      cyc(); cyc();
      n_cmp++;
      if (bus.m_valid !== 1'b0 || busy[1] !== 1'b1) begin
         n_bad++; $display("FAIL st_accept_once: got v=%b busy1=%b want 0 1", bus.m_valid, busy[1]);
      end
      bus.m_bdone = 1'b1;
      cyc();
      bus.m_bdone = 1'b0;
      n_cmp++;
      if (busy[1] !== 1'b0) begin
         n_bad++; $display("FAIL st_bdone: got busy1=%b want 0", busy[1]);
      end
   endtask

   task automatic test_contention();
      pmod_cmd_t c0, c1;
      bit ok;
      do_reset();
      c0 = rand_cmd(1'b1);
      c1 = rand_cmd(1'b0);
      drive_req(0, 1'b1, 1'b0, c0);
      drive_req(1, 1'b0, 1'b1, c1);
      cyc();
      wreq = '0; rreq = '0;
      wait_valid(ok);
      n_cmp++;
      if (!ok || {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata} !== c0) begin
         n_bad++; $display("FAIL ct_first_r0: got ok=%b cmd=%h want 1 %h", ok,
                           {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata}, c0);
      end
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      bus.m_bdone = 1'b1;
      cyc();
      bus.m_bdone = 1'b0;
      n_cmp++;
      if (busy !== 2'b10 || bus.m_valid !== 1'b0) begin
         n_bad++; $display("FAIL ct_gap: got busy=%b v=%b want 10 0", busy, bus.m_valid);
      end
      cyc();
      n_cmp++;
      if (bus.m_valid !== 1'b1 || bus.m_write !== 1'b0 || bus.m_addr !== c1.addr || bus.m_len !== c1.len) begin
         n_bad++; $display("FAIL ct_second_r1: got v=%b w=%b a=%h l=%h want 1 0 %h %h",
                           bus.m_valid, bus.m_write, bus.m_addr, bus.m_len, c1.addr, c1.len);
      end
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = {$urandom, $urandom};
      cyc();
      n_cmp++;
      if (rlast !== 2'b10 || busy !== 2'b00 || rdata[1] !== bus.m_rdata) begin
         n_bad++; $display("FAIL ct_r1_done: got rlast=%b busy=%b want 10 00", rlast, busy);
      end
      idle_inputs();
   endtask

   task automatic test_overflow();
      pmod_cmd_t c0, cx;
      bit ok;
      do_reset();
      c0 = rand_cmd(1'b1);
      drive_req(0, 1'b1, 1'b0, c0);
      cyc();
      n_cmp++;
      if (ovf !== 2'b00) begin
         n_bad++; $display("FAIL ov_clean: got ovf=%b want 00", ovf);
      end
      cx = rand_cmd(1'b1);
      drive_req(0, 1'b1, 1'b0, cx);
      cyc();
      n_cmp++;
      if (ovf !== 2'b01) begin
         n_bad++; $display("FAIL ov_busy_drop: got ovf=%b want 01", ovf);
      end
      cx = rand_cmd(1'b1);
      drive_req(0, 1'b1, 1'b1, cx);
      cyc();
      wreq = '0; rreq = '0;
      wait_valid(ok);
      n_cmp++;
      if (!ok || {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata} !== c0) begin
         n_bad++; $display("FAIL ov_orig_data: got ok=%b cmd=%h want 1 %h", ok,
                           {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata}, c0);
      end
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      bus.m_bdone = 1'b1;
      cyc();
      bus.m_bdone = 1'b0;
      cyc(); cyc(); cyc();
      n_cmp++;
      if (bus.m_valid !== 1'b0 || busy !== 2'b00 || ovf !== 2'b01) begin
         n_bad++; $display("FAIL ov_single_issue: got v=%b busy=%b ovf=%b want 0 00 01", bus.m_valid, busy, ovf);
      end
      c0 = rand_cmd(1'b1);
      drive_req(1, 1'b1, 1'b1, c0);
      cyc();
      wreq = '0; rreq = '0;
      wait_valid(ok);
      n_cmp++;
      if (!ok || ovf !== 2'b11 || {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata} !== c0) begin
         n_bad++; $display("FAIL ov_wr_rd_same: got ok=%b ovf=%b cmd=%h want 1 11 %h", ok, ovf,
                           {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata}, c0);
      end
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      bus.m_bdone = 1'b1;
      cyc();
      bus.m_bdone = 1'b0;
   endtask

   task automatic test_burst_read();
      pmod_cmd_t c;
      logic [DW-1:0] beats [4];
      bit ok;
      int pulses;
      do_reset();
      bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_bdone = 1'b1; bus.m_rdata = {$urandom, $urandom};
      cyc();
      idle_inputs();
      cyc();
      n_cmp++;
      if (rdata !== '0 || rlast !== 2'b00 || busy !== 2'b00 || bus.m_valid !== 1'b0) begin
         n_bad++; $display("FAIL br_stray: got rdata=%h rlast=%b busy=%b v=%b want 0", rdata, rlast, busy, bus.m_valid);
      end
      c = rand_cmd(1'b0);
      drive_req(1, 1'b0, 1'b1, c);
      cyc();
      wreq = '0; rreq = '0;
      wait_valid(ok);
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(0, 1) == 1) cyc();
         beats[k] = {$urandom, $urandom};
         bus.m_rvalid = 1'b1; bus.m_rlast = (k == 3); bus.m_rdata = beats[k];
         cyc();
         bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
         if (rlast[1] === 1'b1) pulses++;
         n_cmp++;
         if (rdata[1] !== beats[k] || busy[1] !== (k != 3) || rdata[0] !== '0) begin
            n_bad++; $display("FAIL br_beat%0d: got rdata1=%h busy1=%b rdata0=%h want %h %b 0",
                              k, rdata[1], busy[1], rdata[0], beats[k], k != 3);
         end
      end
      cyc();
      if (rlast[1] === 1'b1) pulses++;
      n_cmp++;
      if (pulses !== 1) begin
         n_bad++; $display("FAIL br_rlast_once: got %0d pulses want 1", pulses);
      end
   endtask

   task automatic test_reset_mid();
      pmod_cmd_t c;
      bit ok;
      logic [DW-1:0] b;
      c = rand_cmd(1'b0);
      drive_req(0, 1'b0, 1'b1, c);
      cyc();
      wreq = '0; rreq = '0;
      wait_valid(ok);
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      b = {$urandom, $urandom};
      bus.m_rvalid = 1'b1; bus.m_rdata = b;
      cyc();
      bus.m_rvalid = 1'b0;
      n_cmp++;
      if (rdata[0] !== b || busy[0] !== 1'b1) begin
         n_bad++; $display("FAIL rm_partial: got rdata0=%h busy0=%b want %h 1", rdata[0], busy[0], b);
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      n_cmp++;
      if ({busy, rlast, ovf, bus.m_valid, bus.m_write} !== 8'b0 || rdata !== '0 || bus.m_addr !== '0) begin
         n_bad++; $display("FAIL rm_reset: got busy=%b rlast=%b ovf=%b v=%b w=%b rdata=%h a=%h want 0",
                           busy, rlast, ovf, bus.m_valid, bus.m_write, rdata, bus.m_addr);
      end
      bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = {$urandom, $urandom};
      cyc();
      idle_inputs();
      cyc();
      n_cmp++;
      if (rlast !== 2'b00 || rdata !== '0 || bus.m_valid !== 1'b0) begin
         n_bad++; $display("FAIL rm_no_complete: got rlast=%b rdata=%h v=%b want 00 0 0", rlast, rdata, bus.m_valid);
      end
   endtask

   task automatic test_random();
      pmod_cmd_t c;
      bit ok, w;
      int r, nb;
      logic [1:0] mask;
      do_reset();
      for (int round = 0; round < 30; round++) begin
         mask = 2'($urandom_range(1, 3));
         for (int q = 0; q < 2; q++) begin
            if (mask[q]) begin
               w = 1'($urandom_range(0, 1));
               c = rand_cmd(w);
               drive_req(q, w, !w, c);
            end
         end
         cyc();
         wreq = '0; rreq = '0;
         for (int t = 0; t < 2; t++) begin
            if (!(mdl_pend[0] || mdl_pend[1])) break;
            r = model_pick();
            wait_valid(ok);
            n_cmp++;
            if (!ok || {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata} !== mdl_slot[r]) begin
               n_bad++; $display("FAIL rnd_issue%0d: got ok=%b cmd=%h want 1 %h (r%0d)", round, ok,
                                 {bus.m_write, bus.m_len, bus.m_addr, bus.m_wdata}, mdl_slot[r], r);
            end
            repeat ($urandom_range(0, 3)) cyc();
            bus.m_ready = 1'b1;
            cyc();
            bus.m_ready = 1'b0;
            if (mdl_slot[r].write) begin
               repeat ($urandom_range(0, 2)) cyc();
               bus.m_bdone = 1'b1;
            end else begin
               nb = $urandom_range(1, 3);
               for (int k = 0; k < nb; k++) begin
                  bus.m_rvalid = 1'b1; bus.m_rdata = {$urandom, $urandom}; bus.m_rlast = (k == nb - 1);
                  if (k != nb - 1) cyc();
               end
               mdl_rd[r] = bus.m_rdata;
            end
            cyc();
            idle_inputs();
            mdl_pend[r] = 1'b0;
            n_cmp++;
            if (busy[r] !== 1'b0 || rlast[r] !== !mdl_slot[r].write || rdata[r] !== mdl_rd[r]
                || rdata[1-r] !== mdl_rd[1-r] || ovf !== {mdl_ovf[1], mdl_ovf[0]}) begin
               n_bad++; $display("FAIL rnd_done%0d: got busy=%b rlast=%b rdata=%h ovf=%b want r%0d idle rdata %h/%h",
                                 round, busy, rlast, rdata, ovf, r, mdl_rd[1], mdl_rd[0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_ready_stall();
      test_contention();
      test_overflow();
      test_burst_read();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
